// File: rtl/n101_tl_arb_2to1.sv
// Two-master to one-slave TL-UL arbiter: round-robin A grant held while stalled,
// D responses steered back by the master-index bit prepended to the source.
module n101_tl_arb_2to1 #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CW      = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_bits_opcode,
  input  logic [2:0]  m0_a_bits_param,
  input  logic [2:0]  m0_a_bits_size,
  input  logic [1:0]  m0_a_bits_source,
  input  logic [29:0] m0_a_bits_address,
  input  logic [3:0]  m0_a_bits_mask,
  input  logic [31:0] m0_a_bits_data,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  output logic [2:0]  m0_d_bits_opcode,
  output logic [1:0]  m0_d_bits_param,
  output logic [2:0]  m0_d_bits_size,
  output logic [1:0]  m0_d_bits_source,
  output logic        m0_d_bits_error,
  output logic [31:0] m0_d_bits_data,

  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_bits_opcode,
  input  logic [2:0]  m1_a_bits_param,
  input  logic [2:0]  m1_a_bits_size,
  input  logic [1:0]  m1_a_bits_source,
  input  logic [29:0] m1_a_bits_address,
  input  logic [3:0]  m1_a_bits_mask,
  input  logic [31:0] m1_a_bits_data,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  m1_d_bits_opcode,
  output logic [1:0]  m1_d_bits_param,
  output logic [2:0]  m1_d_bits_size,
  output logic [1:0]  m1_d_bits_source,
  output logic        m1_d_bits_error,
  output logic [31:0] m1_d_bits_data,

  output logic        s_a_valid,
  input  logic        s_a_ready,
  output logic [2:0]  s_a_bits_opcode,
  output logic [2:0]  s_a_bits_param,
  output logic [2:0]  s_a_bits_size,
  output logic [2:0]  s_a_bits_source,
  output logic [29:0] s_a_bits_address,
  output logic [3:0]  s_a_bits_mask,
  output logic [31:0] s_a_bits_data,
  input  logic        s_d_valid,
  output logic        s_d_ready,
  input  logic [2:0]  s_d_bits_opcode,
  input  logic [1:0]  s_d_bits_param,
  input  logic [2:0]  s_d_bits_size,
  input  logic [2:0]  s_d_bits_source,
  input  logic        s_d_bits_error,
  input  logic [31:0] s_d_bits_data,

  output logic        busy
);

  logic          rr_q, rr_d;
  logic          lock_q, lock_d;
  logic          lidx_q, lidx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic gidx;
  logic stall;
  logic a_fire;
  logic d_fire;
  logic d_sel;

  assign stall = (cnt_q == CW'(MAX_OUT));

  always_comb begin
    gidx = rr_q;
    if (lock_q)                       gidx = lidx_q;
    else if (m0_a_valid ^ m1_a_valid) gidx = m1_a_valid;
  end

  // A path: purely combinational mux of the granted master
  assign s_a_valid        = (gidx ? m1_a_valid : m0_a_valid) & ~stall;
  assign s_a_bits_opcode  = gidx ? m1_a_bits_opcode  : m0_a_bits_opcode;
  assign s_a_bits_param   = gidx ? m1_a_bits_param   : m0_a_bits_param;
  assign s_a_bits_size    = gidx ? m1_a_bits_size    : m0_a_bits_size;
  assign s_a_bits_address = gidx ? m1_a_bits_address : m0_a_bits_address;
  assign s_a_bits_mask    = gidx ? m1_a_bits_mask    : m0_a_bits_mask;
  assign s_a_bits_data    = gidx ? m1_a_bits_data    : m0_a_bits_data;
  assign s_a_bits_source  = {gidx, (gidx ? m1_a_bits_source : m0_a_bits_source)};

  assign m0_a_ready = s_a_ready & ~stall & ~gidx;
  assign m1_a_ready = s_a_ready & ~stall &  gidx;

  // D path is stateless so it keeps steering correctly across a reset
  assign d_sel      = s_d_bits_source[2];
  assign m0_d_valid = s_d_valid & ~d_sel;
  assign m1_d_valid = s_d_valid &  d_sel;
  assign s_d_ready  = d_sel ? m1_d_ready : m0_d_ready;

  assign m0_d_bits_opcode = s_d_bits_opcode;
  assign m0_d_bits_param  = s_d_bits_param;
  assign m0_d_bits_size   = s_d_bits_size;
  assign m0_d_bits_source = s_d_bits_source[1:0];
  assign m0_d_bits_error  = s_d_bits_error;
  assign m0_d_bits_data   = s_d_bits_data;
  assign m1_d_bits_opcode = s_d_bits_opcode;
  assign m1_d_bits_param  = s_d_bits_param;
  assign m1_d_bits_size   = s_d_bits_size;
  assign m1_d_bits_source = s_d_bits_source[1:0];
  assign m1_d_bits_error  = s_d_bits_error;
  assign m1_d_bits_data   = s_d_bits_data;

  assign a_fire = s_a_valid & s_a_ready;
  assign d_fire = s_d_valid & s_d_ready;
  assign busy   = (cnt_q != '0);

  always_comb begin
    rr_d   = rr_q;
    lock_d = lock_q;
    lidx_d = lidx_q;
    if (a_fire) begin
      lock_d = 1'b0;
      rr_d   = ~gidx;
    end else if (s_a_valid) begin
      lock_d = 1'b1;
      lidx_d = gidx;
    end
  end

  // Saturating decrement absorbs stray responses that outlive a reset
  always_comb begin
    cnt_d = cnt_q;
    if (a_fire && !d_fire)                       cnt_d = cnt_q + 1'b1;
    else if (!a_fire && d_fire && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q   <= 1'b0;
      lock_q <= 1'b0;
      lidx_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      lidx_q <= lidx_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
